// File: rtl/dekatron_ripple_counter.sv
// Dekatron-style BCD up/down counter. Each digit step takes COUNT_DELAY clocks and a
// carry or borrow ripples one digit at a time, so intermediate values show on out_o.
// Optional build macro DEKATRON_COUNTER_SAT_EN: saturate instead of wrapping at the
// top and bottom of the range.
module dekatron_ripple_counter #(
    parameter int unsigned D_NUM       = 6,
    parameter int unsigned COUNT_DELAY = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               request_i,
    input  logic               dec_i,
    input  logic               set_i,
    input  logic [D_NUM*4-1:0] in_i,
    output logic               ready_o,
    output logic [D_NUM*4-1:0] out_o,
    output logic               zero_o,
    output logic               carry_o
);

    localparam int unsigned CW = (COUNT_DELAY > 1) ? $clog2(COUNT_DELAY) : 1;
    localparam int unsigned PW = (D_NUM > 1) ? $clog2(D_NUM) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StStep, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               dec_q, dec_d;
    logic [D_NUM*4-1:0] in_q, in_d;
    logic [D_NUM*4-1:0] out_q, out_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic [3:0]         digit_cur;
    logic [3:0]         digit_new;
    logic               ripple;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            dec_q   <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            dec_q   <= dec_d;
            in_q    <= in_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Digit under the ripple pointer and its stepped value.
    always_comb begin
        digit_cur = out_q[32'(ptr_q)*4 +: 4];
        if (dec_q) begin
            ripple    = (digit_cur == 4'd0);
            digit_new = ripple ? 4'd9 : digit_cur - 4'd1;
        end else begin
            ripple    = (digit_cur >= 4'd9);
            digit_new = ripple ? 4'd0 : digit_cur + 4'd1;
        end
    end

    // Next-state logic: accept in idle, wait out the tube delay, then load or step a digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        dec_d   = dec_q;
        in_d    = in_q;
        out_d   = out_q;
        carry_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (request_i) begin
                    dec_d   = dec_i;
                    in_d    = in_i;
                    cnt_d   = CW'(COUNT_DELAY - 1);
                    ptr_d   = '0;
                    state_d = set_i ? StLoad : StStep;
                end
            end
            StLoad: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < int'(D_NUM); i++) begin
                        out_d[i*4 +: 4] = (in_q[i*4 +: 4] > 4'd9) ? 4'd9 : in_q[i*4 +: 4];
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStep: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
`ifdef DEKATRON_COUNTER_SAT_EN
                end else if (ptr_q == '0 &&
                             (dec_q ? (out_q == '0) : (out_q == {D_NUM{4'h9}}))) begin
                    // Range limit reached: hold the value but still flag the attempt.
                    carry_d = 1'b1;
                    state_d = StDone;
`endif
                end else begin
                    out_d[32'(ptr_q)*4 +: 4] = digit_new;
                    if (!ripple) begin
                        state_d = StDone;
                    end else if (ptr_q == PW'(D_NUM - 1)) begin
                        carry_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = CW'(COUNT_DELAY - 1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Zero follows every digit update, including ripple intermediates.
        zero_d = (out_d == '0);
    end

    assign ready_o = (state_q == StIdle);
    assign out_o   = out_q;
    assign zero_o  = zero_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_dekatron_ripple_counter.sv
// Bench for dekatron_ripple_counter: directed steps plus random operations, checked
// against an integer model of the counter value and its per-digit ripple timing.
module tb_dekatron_ripple_counter;

    localparam int unsigned D_NUM = 6;
    localparam int unsigned CD    = 3;
    localparam int          W     = D_NUM * 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         request = 1'b0;
    logic         dec = 1'b0;
    logic         set = 1'b0;
    logic [W-1:0] din = '0;
    logic         ready_o;
    logic [W-1:0] out_o;
    logic         zero_o;
    logic         carry_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int mval   = 0;
    int modv;

    dekatron_ripple_counter #(
        .D_NUM      (D_NUM),
        .COUNT_DELAY(CD)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .request_i(request),
        .dec_i    (dec),
        .set_i    (set),
        .in_i     (din),
        .ready_o  (ready_o),
        .out_o    (out_o),
        .zero_o   (zero_o),
        .carry_o  (carry_o)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(D_NUM); i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Decimal value of a load word, with any digit above 9 read as 9.
    function automatic int load_val(input logic [W-1:0] b);
        int acc = 0;
        int d;
        for (int i = int'(D_NUM) - 1; i >= 0; i--) begin
            d = int'(b[i*4 +: 4]);
            if (d > 9) d = 9;
            acc = acc * 10 + d;
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One operation accepted at a posedge; checks every cycle until ready returns.
    task automatic run_op(input bit op_set, input bit op_dec, input logic [W-1:0] op_in,
                          input bit hold_req, input bit toggle_dec);
        int wait_n = 0;
        int lat, nupd, u, tr, x, fin, cur;
        bit wrap = 1'b0;
        while (ready_o !== 1'b1 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        chk("ready_before_op", 32'(ready_o), 32'd1);
        request = 1'b1;
        set     = op_set;
        dec     = op_dec;
        din     = op_in;
        @(posedge clk);
        @(negedge clk);
        if (!hold_req) request = 1'b0;

        if (op_set) begin
            nupd = 1;
            fin  = load_val(op_in);
        end else begin
            tr = 0;
            x  = mval;
            while (tr < int'(D_NUM) && (x % 10) == (op_dec ? 0 : 9)) begin
                tr++;
                x = x / 10;
            end
            wrap = (tr == int'(D_NUM));
            nupd = wrap ? int'(D_NUM) : tr + 1;
            fin  = op_dec ? (mval + modv - 1) % modv : (mval + 1) % modv;
`ifdef DEKATRON_COUNTER_SAT_EN
            if (wrap) begin
                nupd = 1;
                fin  = mval;
            end
`endif
        end
        lat = int'(CD) * nupd;

        for (int i = 0; i <= lat + 1; i++) begin
            if (toggle_dec && i == 1) begin
                dec = ~dec;
                din = W'($urandom);
            end
            u = i / int'(CD);
            if (u > nupd) u = nupd;
            if (u == 0) cur = mval;
            else if (u == nupd) cur = fin;
            else cur = op_dec ? mval + (pow10(u) - 1) : mval - (pow10(u) - 1);
            chk("out", 32'(out_o), 32'(to_bcd(cur)));
            chk("zero", 32'(zero_o), 32'(cur == 0));
            chk("carry", 32'(carry_o), 32'(wrap && i == lat));
            chk("ready", 32'(ready_o), 32'(i == lat + 1));
            if (i <= lat) @(negedge clk);
        end
        mval = fin;
    endtask

    initial begin
        modv = pow10(int'(D_NUM));

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out_o), 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd1);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_carry", 32'(carry_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of the 000009 -> 000010 ripple.
        run_op(1'b1, 1'b0, to_bcd(9), 1'b0, 1'b0);
        request = 1'b1;
        set     = 1'b0;
        dec     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        request = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out", 32'(out_o), 32'd0);
        chk("midrst_zero", 32'(zero_o), 32'd1);
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_carry", 32'(carry_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_hold_out", 32'(out_o), 32'd0);
            chk("midrst_hold_ready", 32'(ready_o), 32'd1);
        end
        mval = 0;

        // 100 increments then 100 decrements.
        for (int n = 0; n < 100; n++) run_op(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("after_ups", 32'(out_o), 32'h000100);
        for (int n = 0; n < 100; n++) run_op(1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("after_downs", 32'(out_o), 32'h000000);
        chk("after_downs_zero", 32'(zero_o), 32'd1);

        // Load 39 and count down to zero; clamped load.
        run_op(1'b1, 1'b0, W'(24'h000039), 1'b0, 1'b0);
        for (int n = 0; n < 39; n++) run_op(1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("load39_down_end", 32'(out_o), 32'h000000);
        run_op(1'b1, 1'b0, W'(24'h0000AF), 1'b0, 1'b0);
        chk("clamp_load", 32'(out_o), 32'h000099);

        // Full-width wrap up and borrow down.
        run_op(1'b1, 1'b0, {D_NUM{4'h9}}, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, '0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, '0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, '0, 1'b0, 1'b0);

        // Request held through a busy operation with dec toggled: one step only.
        run_op(1'b1, 1'b0, W'(24'h000457), 1'b0, 1'b0);
        run_op(1'b0, 1'b0, '0, 1'b1, 1'b1);
        request = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_req_out", 32'(out_o), 32'h000458);
        chk("held_req_ready", 32'(ready_o), 32'd1);

        // Back-to-back operations with Request never dropped.
        for (int n = 0; n < 3; n++) run_op(1'b0, 1'b0, '0, 1'b1, 1'b0);
        request = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_out", 32'(out_o), 32'h000461);

        // Random operations, including unclamped load digits.
        for (int n = 0; n < 40; n++) begin
            run_op(1'b0 ^ ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   W'($urandom), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
